// File: rtl/wma_pkg.sv
// Shared constants and types for the world-map read-port arbiter.
// Map is 128x128 cells of 2 bits, addressed {row[6:0], col[6:0]}.
package wma_pkg;

  localparam int MAP_ADDR_W = 14;
  localparam int MAP_DATA_W = 2;
  localparam int VID_LAT    = 3;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_VID  = 2'd1,
    SRC_BOT  = 2'd2
  } src_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/wma_delay.sv
// Fixed-depth shift register with synchronous clear; DEPTH cycles of latency, no stall.
module wma_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/world_map_arbiter.sv
// Shares the world-map BRAM read port: video scan has fixed priority and 3-cycle latency,
// bot lookups take free slots and ack at grant+3. WMA_STATS_EN adds bot_wait_max.
module world_map_arbiter
  import wma_pkg::*;
#(
  parameter int SCALE_SHIFT_X = 3,
  parameter int SCALE_SHIFT_Y = 3,
  parameter int MAP_AW        = MAP_ADDR_W,
  parameter int PIX_W         = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PIX_W-1:0]      pix_row,
  input  logic [PIX_W-1:0]      pix_col,
  input  logic                  video_on_in,
  input  logic                  bot_req,
  input  logic [MAP_AW-1:0]     bot_addr,
  output logic                  bot_ack,
  output logic [MAP_DATA_W-1:0] bot_data,
  output logic                  mem_en,
  output logic [MAP_AW-1:0]     mem_addr,
  input  logic [MAP_DATA_W-1:0] mem_rdata,
  output logic [MAP_DATA_W-1:0] world_pixel,
  output logic                  video_on_out
`ifdef WMA_STATS_EN
  ,
  output logic [7:0]            bot_wait_max
`endif
);

  localparam int CW = MAP_AW / 2;

  state_e                state_q, state_d;
  src_e                  tag1_q, tag2_q, tag_d;
  logic                  mem_en_q, mem_en_d;
  logic [MAP_AW-1:0]     mem_addr_q, mem_addr_d;
  logic [MAP_DATA_W-1:0] tile_q;
  logic                  bot_ack_q;
  logic [MAP_DATA_W-1:0] bot_data_q;

  logic                  vid_need;
  logic [CW-1:0]         vid_row, vid_col;
  logic [MAP_AW-1:0]     vid_addr;

  // Cell coordinates wrap past 128; unreachable at the default 96-row scale.
  assign vid_row  = CW'(pix_row >> SCALE_SHIFT_Y);
  assign vid_col  = CW'(pix_col >> SCALE_SHIFT_X);
  assign vid_addr = {vid_row, vid_col};
  assign vid_need = video_on_in && (pix_col[SCALE_SHIFT_X-1:0] == '0);

  always_comb begin
    state_d    = state_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    tag_d      = SRC_NONE;
    if (vid_need) begin
      mem_en_d   = 1'b1;
      mem_addr_d = vid_addr;
      tag_d      = SRC_VID;
    end else if (state_q == IDLE && bot_req) begin
      mem_en_d   = 1'b1;
      mem_addr_d = bot_addr;
      tag_d      = SRC_BOT;
      state_d    = WAIT;
    end
    // Release as the ack is registered so a held request can be re-granted in the ack cycle.
    if (tag2_q == SRC_BOT) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      tag1_q     <= SRC_NONE;
      tag2_q     <= SRC_NONE;
      tile_q     <= '0;
      bot_ack_q  <= 1'b0;
      bot_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      tag1_q     <= tag_d;
      tag2_q     <= tag1_q;
      bot_ack_q  <= (tag2_q == SRC_BOT);
      if (tag2_q == SRC_VID) tile_q     <= mem_rdata;
      if (tag2_q == SRC_BOT) bot_data_q <= mem_rdata;
    end
  end

  wma_delay #(
    .WIDTH(1),
    .DEPTH(VID_LAT)
  ) u_von_dly (
    .clk   (clk),
    .reset (reset),
    .din_i (video_on_in),
    .dout_o(video_on_out)
  );

  assign mem_en      = mem_en_q;
  assign mem_addr    = mem_addr_q;
  assign bot_ack     = bot_ack_q;
  assign bot_data    = bot_data_q;
  assign world_pixel = tile_q;

`ifdef WMA_STATS_EN
  logic       bot_grant;
  logic [7:0] wait_cnt_q, wait_max_q;

  assign bot_grant = !vid_need && (state_q == IDLE) && bot_req;

  // Wait is counted from the first IDLE cycle with bot_req high up to the grant cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      wait_max_q <= '0;
    end else if (bot_grant) begin
      if (wait_cnt_q > wait_max_q) wait_max_q <= wait_cnt_q;
      wait_cnt_q <= '0;
    end else if (state_q == IDLE && bot_req) begin
      if (wait_cnt_q != 8'hFF) wait_cnt_q <= wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_q <= '0;
    end
  end

  assign bot_wait_max = wait_max_q;
`endif

endmodule

// File: doc/world_map_arbiter.md
Name: world_map_arbiter

Overview:
- Owns the single read port of the 128x128 x 2-bit world-map BRAM and shares it between two requesters.
- Requester 1 is the video scan path, which feeds world_pixel and video_on to the colorizer.
- Requester 2 is the Rojobot sensor/position lookup engine.
- Video has fixed priority and fixed latency. Bot lookups use free slots through a req/ack handshake.

Parameters:
- SCALE_SHIFT_X, 3, log2 of horizontal display pixels per map cell (1024>>3 = 128 columns); must be >= 1.
- SCALE_SHIFT_Y, 3, log2 of vertical display pixels per map cell (768>>3 = 96 rows used).
- MAP_AW, 14, map address width, {row[6:0], col[6:0]}.
- PIX_W, 11, width of pixel row/column inputs.

Ports:
- clk  in  1  pixel clock; one pixel per cycle.
- reset  in  1  synchronous, active-high reset.
- pix_row  in  PIX_W  current scan row from the timing generator.
- pix_col  in  PIX_W  current scan column.
- video_on_in  in  1  active-video flag aligned with pix_row/pix_col.
- bot_req  in  1  bot lookup request; level, held until bot_ack.
- bot_addr  in  MAP_AW  bot lookup address; stable while bot_req is high.
- bot_ack  out  1  one-cycle pulse; bot_data valid in the same cycle.
- bot_data  out  2  map value returned for bot_addr.
- mem_en  out  1  BRAM read enable (registered).
- mem_addr  out  MAP_AW  BRAM read address (registered).
- mem_rdata  in  2  BRAM data; valid the cycle after the cycle mem_en is high.
- world_pixel  out  2  map value for the delayed pixel; drives the colorizer.
- video_on_out  out  1  video_on_in delayed to align with world_pixel.

Behaviour:
- Reset values: mem_en=0, mem_addr=0, bot_ack=0, bot_data=0, world_pixel=0, video_on_out=0. FSM goes to IDLE, delay line clears, source tags go to NONE.
- Video need (combinational):
  - vid_need = video_on_in & (pix_col[SCALE_SHIFT_X-1:0]==0).
  - vid_addr = {pix_row>>SCALE_SHIFT_Y [6:0], pix_col>>SCALE_SHIFT_X [6:0]}.
- Slot arbitration, each cycle, strict priority:
  - If vid_need: register mem_en=1, mem_addr=vid_addr, tag=VID.
  - Else if FSM==IDLE & bot_req: register mem_en=1, mem_addr=bot_addr, tag=BOT, FSM to WAIT. This cycle is the grant cycle g.
  - Else mem_en=0, tag=NONE.
- Tag pipeline: the tag is delayed one more cycle to line up with mem_rdata. Then:
  - tag VID: tile_reg <= mem_rdata.
  - tag BOT: bot_data <= mem_rdata, bot_ack <= 1 for one cycle, FSM to IDLE.
- Bot latency: bot_ack is high in cycle g+3 exactly.
  - A request that arrives while vid_need is high is granted in the next non-video cycle. Because SCALE_SHIFT_X >= 1, the wait is at most 1 cycle.
  - During blanking, the grant is immediate.
- FSM states:
  - IDLE: grant allowed.
  - WAIT: outstanding request; bot_req is ignored.
  - Returns to IDLE in the cycle bot_ack is registered high. A new grant is possible in the cycle bot_ack is visible, provided bot_req is still high.
- Video latency: world_pixel and video_on_out lag pix_row/pix_col/video_on_in by exactly 3 cycles.
  - world_pixel = tile_reg. It updates at the first pixel of each cell and holds for 2^SCALE_SHIFT_X pixels.
- Blanking: no video reads. world_pixel holds its last value; video_on_out=0 masks it downstream.
- Cell boundary coinciding with bot_req: video wins; bot is granted the next cycle.
- Reset mid-transaction:
  - Outstanding bot read is dropped; no bot_ack is issued.
  - The bot must re-assert bot_req after reset deasserts.
- Address arithmetic: the shifted row is truncated to 7 bits, so rows >= 128 wrap. With default parameters this cannot occur (96 rows).

Optional Feature:
- Macro: WMA_STATS_EN.
- With it defined:
  - Adds output port bot_wait_max [7:0].
  - Holds the largest number of cycles any bot request waited from the first cycle bot_req is high in IDLE to grant.
  - Saturates at 255; cleared by reset.
- Without it: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package wma_pkg:
  - MAP_AW and data width constants.
  - Source-tag enum SRC_NONE/SRC_VID/SRC_BOT.
  - FSM state enum IDLE/WAIT.
  - Fixed video latency constant VID_LAT=3.
- Sub-module wma_delay: parameterized width/depth shift register with synchronous reset. Used for the video_on alignment.

Test Plan:
- Reset high for 2 cycles with bot_req=1: all outputs 0, no mem_en. After release, grant on the first non-video cycle.
- Blanking, bot_req with bot_addr=14'h0085, memory holds 2'b10 there: mem_en/mem_addr=0x0085 in g+1, bot_ack pulse in g+3 with bot_data=2'b10, single pulse only.
- Active line, pix_row=16, pix_col=0..15, map cells (2,0)=01 and (2,1)=10:
  - mem_addr 0x0100 then 0x0101, reads 8 cycles apart.
  - world_pixel 01 for 8 cycles then 10, lagging 3 cycles; video_on_out aligned.
- bot_req rises in the same cycle as pix_col=8 (video need): video read issued first, bot granted the next cycle, bot_ack 4 cycles after req rise, video output undisturbed.
- Back-to-back bot requests with bot_req held through ack: second grant in the ack cycle, acks spaced 3 cycles apart in blanking.
- Reset asserted in g+1 of a bot read: no bot_ack emitted; FSM IDLE. With WMA_STATS_EN, bot_wait_max=0 after reset.
